// File: rtl/bcd_entry_reg.sv
// ---------------------------------------------------------------------------
// bcd_entry_reg
//
// Keypad-driven BCD number entry register. Each key press (rising edge of
// keystrobe, seen once per press no matter how long it is held) performs one
// action: digit entry, backspace, clear, Enter (latch operand) or sign toggle.
//
// Parameters
//   NDIGITS      number of BCD digits held (2..8)
//   CLR_ON_ENTER 1 = live entry clears when Enter latches the operand
//
// Ports
//   clock        system clock, all state changes on its rising edge
//   resetn       asynchronous active-low reset
//   keycode      key code from the keypad scanner, valid while keystrobe=1
//   keystrobe    high while a key is held
//   bcd_out      live entry digits, digit 0 at bits [3:0]
//   blank        per-digit leading-zero blank mask (1 = blank the digit)
//   neg          sign of the live entry (1 = negative)
//   digit_count  number of digits entered, 0..NDIGITS
//   overflow     sticky: a digit was rejected because the entry was full
//   value_out    operand latched on Enter
//   value_neg    sign latched on Enter
//   entry_valid  one-cycle pulse when value_out/value_neg were updated
// ---------------------------------------------------------------------------
module bcd_entry_reg #(
    parameter int NDIGITS      = 3,
    parameter bit CLR_ON_ENTER = 1'b1
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [3:0]           keycode,
    input  logic                 keystrobe,
    output logic [4*NDIGITS-1:0] bcd_out,
    output logic [NDIGITS-1:0]   blank,
    output logic                 neg,
    output logic [3:0]           digit_count,
    output logic                 overflow,
    output logic [4*NDIGITS-1:0] value_out,
    output logic                 value_neg,
    output logic                 entry_valid
);

    typedef enum logic {
        WAIT_PRESS,
        WAIT_RELEASE
    } state_t;

    localparam logic [3:0] MAX_COUNT = 4'(NDIGITS);

    state_t               state;
    state_t               state_next;
    logic                 strobe_q;
    logic                 key_event;

    logic [4*NDIGITS-1:0] digits_q;
    logic [3:0]           count_q;
    logic                 neg_q;
    logic                 overflow_q;
    logic [4*NDIGITS-1:0] value_q;
    logic                 value_neg_q;
    logic                 entry_valid_q;

    // Press tracking: state register plus the registered copy of keystrobe
    // used to find its rising edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= WAIT_PRESS;
            strobe_q <= 1'b0;
        end else begin
            state    <= state_next;
            strobe_q <= keystrobe;
        end
    end

    // A key event is only accepted while waiting for a press, so a held key
    // produces exactly one action and keycode changes while held are ignored.
    always_comb begin
        state_next = state;
        key_event  = 1'b0;
        case (state)
            WAIT_PRESS: begin
                if (keystrobe && !strobe_q) begin
                    key_event  = 1'b1;
                    state_next = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (!keystrobe) begin
                    state_next = WAIT_PRESS;
                end
            end
            default: state_next = WAIT_PRESS;
        endcase
    end

    // Entry datapath: the key action is committed at the event edge itself.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            digits_q      <= '0;
            count_q       <= 4'd0;
            neg_q         <= 1'b0;
            overflow_q    <= 1'b0;
            value_q       <= '0;
            value_neg_q   <= 1'b0;
            entry_valid_q <= 1'b0;
        end else begin
            entry_valid_q <= 1'b0;
            if (key_event) begin
                case (keycode)
                    4'hA: begin
                        digits_q   <= {4'd0, digits_q[4*NDIGITS-1:4]};
                        if (count_q != 4'd0) begin
                            count_q <= count_q - 4'd1;
                        end
                        // The sign has no meaning once the entry is empty.
                        if (count_q <= 4'd1) begin
                            neg_q <= 1'b0;
                        end
                        overflow_q <= 1'b0;
                    end
                    4'hB: begin
                        digits_q   <= '0;
                        count_q    <= 4'd0;
                        neg_q      <= 1'b0;
                        overflow_q <= 1'b0;
                    end
                    4'hC: begin
                        value_q       <= digits_q;
                        value_neg_q   <= neg_q;
                        entry_valid_q <= 1'b1;
                        overflow_q    <= 1'b0;
                        if (CLR_ON_ENTER) begin
                            digits_q <= '0;
                            count_q  <= 4'd0;
                            neg_q    <= 1'b0;
                        end
                    end
                    4'hD: begin
                        if (count_q != 4'd0) begin
                            neg_q <= ~neg_q;
                        end
                    end
                    4'hE, 4'hF: begin
                    end
                    default: begin
                        // Digits 0..9. A leading zero is never stored.
                        if (count_q == MAX_COUNT) begin
                            overflow_q <= 1'b1;
                        end else if (!(count_q == 4'd0 && keycode == 4'd0)) begin
                            digits_q <= {digits_q[4*NDIGITS-5:0], keycode};
                            count_q  <= count_q + 4'd1;
                        end
                    end
                endcase
            end
        end
    end

    // Digits above the entered count are blanked; digit 0 always shows so an
    // empty entry reads as a single "0".
    always_comb begin
        blank = '0;
        for (int i = 1; i < NDIGITS; i++) begin
            blank[i] = (4'(i) >= count_q);
        end
    end

    assign bcd_out     = digits_q;
    assign neg         = neg_q;
    assign digit_count = count_q;
    assign overflow    = overflow_q;
    assign value_out   = value_q;
    assign value_neg   = value_neg_q;
    assign entry_valid = entry_valid_q;

endmodule

// File: tb/tb_bcd_entry_reg.sv
// ---------------------------------------------------------------------------
// tb_bcd_entry_reg
//
// Self-checking bench for bcd_entry_reg (NDIGITS=3, CLR_ON_ENTER=1).
// The reference model holds the entry as a plain decimal integer plus a digit
// count and flags; the expected BCD image and blank mask are derived from it.
// Outputs are compared against the model on every falling clock edge, and a
// set of directed scenarios also compare against hand-worked literal values.
// ---------------------------------------------------------------------------
module tb_bcd_entry_reg;

    localparam int N = 3;

    logic           clock;
    logic           resetn;
    logic [3:0]     keycode;
    logic           keystrobe;
    logic [4*N-1:0] bcd_out;
    logic [N-1:0]   blank;
    logic           neg;
    logic [3:0]     digit_count;
    logic           overflow;
    logic [4*N-1:0] value_out;
    logic           value_neg;
    logic           entry_valid;

    bcd_entry_reg #(
        .NDIGITS     (N),
        .CLR_ON_ENTER(1'b1)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .keycode    (keycode),
        .keystrobe  (keystrobe),
        .bcd_out    (bcd_out),
        .blank      (blank),
        .neg        (neg),
        .digit_count(digit_count),
        .overflow   (overflow),
        .value_out  (value_out),
        .value_neg  (value_neg),
        .entry_valid(entry_valid)
    );

    // Reference model state: the entry is an ordinary decimal number.
    int  exp_val;
    int  exp_cnt;
    bit  exp_neg;
    bit  exp_ovf;
    int  exp_vout;
    bit  exp_vneg;
    bit  exp_ev;

    int  total;
    int  bad;
    bit  check_en;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Digits shown = entered count, but never fewer than one.
    function automatic logic [31:0] exp_blank(input int cnt);
        logic [31:0] m;
        int shown;
        m = '0;
        shown = (cnt > 0) ? cnt : 1;
        for (int i = 0; i < N; i++) begin
            if (i >= shown) m[i] = 1'b1;
        end
        return m;
    endfunction

    task automatic model_clear();
        exp_val = 0;
        exp_cnt = 0;
        exp_neg = 1'b0;
        exp_ovf = 1'b0;
    endtask

    task automatic model_reset();
        model_clear();
        exp_vout = 0;
        exp_vneg = 1'b0;
        exp_ev   = 1'b0;
    endtask

    task automatic model_key(input logic [3:0] k);
        if (k <= 4'd9) begin
            if (exp_cnt == N) begin
                exp_ovf = 1'b1;
            end else if (!(exp_cnt == 0 && k == 4'd0)) begin
                exp_val = exp_val * 10 + int'(k);
                exp_cnt++;
            end
        end else if (k == 4'hA) begin
            exp_val = exp_val / 10;
            if (exp_cnt > 0) exp_cnt--;
            exp_ovf = 1'b0;
            if (exp_cnt == 0) exp_neg = 1'b0;
        end else if (k == 4'hB) begin
            model_clear();
        end else if (k == 4'hC) begin
            exp_vout = exp_val;
            exp_vneg = exp_neg;
            exp_ev   = 1'b1;
            model_clear();
        end else if (k == 4'hD) begin
            if (exp_cnt > 0) exp_neg = !exp_neg;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        check("bcd_out",     32'(bcd_out),     to_bcd(exp_val));
        check("blank",       32'(blank),       exp_blank(exp_cnt));
        check("neg",         32'(neg),         32'(exp_neg));
        check("digit_count", 32'(digit_count), 32'(exp_cnt));
        check("overflow",    32'(overflow),    32'(exp_ovf));
        check("value_out",   32'(value_out),   to_bcd(exp_vout));
        check("value_neg",   32'(value_neg),   32'(exp_vneg));
        check("entry_valid", 32'(entry_valid), 32'(exp_ev));
    endtask

    // Continuous comparison against the model, away from the rising edge.
    always @(negedge clock) begin
        if (check_en) checkOutput();
    end

    // One rising edge with no key event.
    task automatic tick();
        @(posedge clock);
        #1;
        exp_ev = 1'b0;
    endtask

    // Raise keystrobe; the next rising edge is the event edge.
    task automatic press_start(input logic [3:0] k);
        keycode   = k;
        keystrobe = 1'b1;
        @(posedge clock);
        #1;
        exp_ev = 1'b0;
        model_key(k);
    endtask

    // Keep the key held for 'extra' more edges (optionally scrambling the
    // code), then release for 'gap' edges.
    task automatic press_finish(input int extra, input int gap, input bit scramble);
        for (int i = 0; i < extra; i++) begin
            if (scramble) keycode = 4'($urandom_range(0, 15));
            tick();
        end
        keystrobe = 1'b0;
        for (int i = 0; i < gap; i++) tick();
    endtask

    task automatic applyStimulus(input logic [3:0] k, input int hold, input int gap,
                                 input bit scramble);
        press_start(k);
        press_finish(hold - 1, gap, scramble);
    endtask

    task automatic doReset();
        #1;
        resetn = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
        resetn = 1'b1;
        tick();
    endtask

    initial begin
        int r;
        int hold;
        int gap;
        logic [3:0] k;

        total     = 0;
        bad       = 0;
        check_en  = 1'b0;
        resetn    = 1'b1;
        keystrobe = 1'b0;
        keycode   = 4'd0;
        model_reset();

        // Power-on reset, checked without any clock edge.
        #1;
        resetn   = 1'b0;
        check_en = 1'b1;
        #1;
        check("por bcd_out",     32'(bcd_out),     32'h000);
        check("por blank",       32'(blank),       32'b110);
        check("por digit_count", 32'(digit_count), 32'd0);
        check("por entry_valid", 32'(entry_valid), 32'd0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        tick();

        // 1, 2, 3 held five cycles each.
        applyStimulus(4'd1, 5, 2, 1'b0);
        applyStimulus(4'd2, 5, 2, 1'b0);
        applyStimulus(4'd3, 5, 2, 1'b0);
        check("full bcd_out",     32'(bcd_out),     32'h123);
        check("full digit_count", 32'(digit_count), 32'd3);
        check("full blank",       32'(blank),       32'b000);

        // Fourth digit rejected, then backspace.
        applyStimulus(4'd4, 3, 2, 1'b0);
        check("ovf bcd_out",  32'(bcd_out),  32'h123);
        check("ovf overflow", 32'(overflow), 32'd1);
        applyStimulus(4'hA, 3, 2, 1'b0);
        check("bksp bcd_out",     32'(bcd_out),     32'h012);
        check("bksp digit_count", 32'(digit_count), 32'd2);
        check("bksp overflow",    32'(overflow),    32'd0);
        check("bksp blank",       32'(blank),       32'b100);
        applyStimulus(4'hB, 2, 2, 1'b0);

        // Leading zeros are not stored.
        applyStimulus(4'd0, 2, 1, 1'b0);
        applyStimulus(4'd0, 2, 1, 1'b0);
        applyStimulus(4'd7, 2, 1, 1'b0);
        check("lz bcd_out",     32'(bcd_out),     32'h007);
        check("lz digit_count", 32'(digit_count), 32'd1);
        check("lz blank",       32'(blank),       32'b110);
        applyStimulus(4'hB, 2, 2, 1'b0);

        // 45, negate, Enter.
        applyStimulus(4'd4, 2, 1, 1'b0);
        applyStimulus(4'd5, 2, 1, 1'b0);
        applyStimulus(4'hD, 2, 1, 1'b0);
        press_start(4'hC);
        check("enter entry_valid", 32'(entry_valid), 32'd1);
        check("enter value_out",   32'(value_out),   32'h045);
        check("enter value_neg",   32'(value_neg),   32'd1);
        check("enter bcd_out",     32'(bcd_out),     32'h000);
        check("enter neg",         32'(neg),         32'd0);
        tick();
        check("enter pulse end",   32'(entry_valid), 32'd0);
        press_finish(2, 2, 1'b0);

        // Long hold gives one digit; sign toggle on an empty entry is ignored.
        applyStimulus(4'd9, 100, 2, 1'b1);
        check("hold bcd_out",     32'(bcd_out),     32'h009);
        check("hold digit_count", 32'(digit_count), 32'd1);
        applyStimulus(4'hB, 2, 1, 1'b0);
        applyStimulus(4'hD, 2, 1, 1'b0);
        check("empty neg", 32'(neg), 32'd0);

        // Reset in the middle of a press, key still held at release.
        applyStimulus(4'd5, 2, 1, 1'b0);
        applyStimulus(4'd6, 2, 1, 1'b0);
        check("pre-reset bcd_out", 32'(bcd_out), 32'h056);
        keycode   = 4'd7;
        keystrobe = 1'b1;
        #1;
        resetn = 1'b0;
        model_reset();
        #1;
        check("async bcd_out",     32'(bcd_out),     32'h000);
        check("async digit_count", 32'(digit_count), 32'd0);
        check("async blank",       32'(blank),       32'b110);
        check("async value_out",   32'(value_out),   32'h000);
        check("async value_neg",   32'(value_neg),   32'd0);
        tick();
        tick();
        resetn = 1'b1;
        @(posedge clock);
        #1;
        exp_ev = 1'b0;
        model_key(4'd7);
        press_finish(4, 2, 1'b0);
        check("held-release bcd_out",     32'(bcd_out),     32'h007);
        check("held-release digit_count", 32'(digit_count), 32'd1);

        // Randomized presses against the model.
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) doReset();
            if ($urandom_range(0, 2) != 0) k = 4'($urandom_range(0, 9));
            else                           k = 4'($urandom_range(10, 15));
            hold = int'($urandom_range(1, 4));
            gap  = int'($urandom_range(1, 3));
            applyStimulus(k, hold, gap, 1'($urandom_range(0, 1)));
        end

        tick();
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
